// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU-immediate sequencer.
package alu_seq_pkg;

    // Sequencer states; IDLE is first so a cleared state register reads as idle.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SRC   = 3'd1,
        IMM   = 3'd2,
        EXEC  = 3'd3,
        LATCH = 3'd4,
        WB    = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    // Only instruction class the sequencer executes.
    localparam logic [3:0] CLASS_ALU_IMM = 4'h0;

    // ALU function codes carried in the op field.
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;

    // Width of the EXEC wait counter; ALU_LAT is limited to 0..15.
    localparam int LAT_CNT_W = 4;

    // True for the states in which alu_op is driven with the captured op.
    function automatic logic op_window(input state_t s);
        return (s == SRC) || (s == IMM) || (s == EXEC) || (s == LATCH);
    endfunction

endpackage

// File: rtl/imm_ext.sv
// Immediate extender: widens (or truncates) the instruction immediate to the datapath width.
module imm_ext #(
    parameter int IMM_W      = 6,
    parameter int DATA_W     = 16,
    parameter bit IMM_SIGNED = 1'b0
) (
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] ext
);

    generate
        if (IMM_W >= DATA_W) begin : g_trunc
            // Immediate at least as wide as the bus: keep the low bits only.
            assign ext = imm[DATA_W-1:0];
        end else if (IMM_SIGNED) begin : g_sext
            // Replicate the immediate MSB into the upper bits.
            assign ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        end else begin : g_zext
            // Upper bits are zero.
            assign ext = {{(DATA_W-IMM_W){1'b0}}, imm};
        end
    endgenerate

endmodule

// File: rtl/alu_imm_seq.sv
// ALU-immediate sequencer: takes one "ALU Rd, #imm" instruction per handshake and
// steps the shared bus through operand load, ALU wait, result latch and write-back.
//
// Handshake: an instruction is taken on a rising clk edge where instr_valid and
// instr_ready are both high; instr_ready is high only in IDLE while out of reset,
// so instr is ignored for the whole sequence and must stay stable only until taken.
module alu_imm_seq
    import alu_seq_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 2,
    parameter bit IMM_SIGNED = 1'b0,
    parameter int ALU_LAT    = 0,
    localparam int NUM_REGS  = 2 ** REG_ADDR_W,
    localparam int IMM_W     = INSTR_W - 8 - REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic                  busy,
    output logic [3:0]            alu_op,
    output logic [NUM_REGS-1:0]   rx_out,
    output logic                  alu_in0,
    output logic                  alu_in1,
    output logic [DATA_W-1:0]     param2_out,
    output logic                  alu_out_latch,
    output logic                  alu_out_en,
    output logic [NUM_REGS-1:0]   rx_in,
    output logic                  pc_inc,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    // Counter preload: EXEC lasts ALU_LAT cycles, counting down to zero.
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
        (ALU_LAT > 0) ? LAT_CNT_W'(ALU_LAT - 1) : '0;

    state_t                 state;
    state_t                 state_n;
    logic [INSTR_W-1:0]     ir;
    logic [INSTR_W-1:0]     ir_n;
    logic [LAT_CNT_W-1:0]   cnt;
    logic [LAT_CNT_W-1:0]   cnt_n;
    logic                   accept;

    // Fields of the instruction as it will be held next cycle.
    logic [3:0]             cls_n;
    logic [3:0]             op_n;
    logic [REG_ADDR_W-1:0]  rd_n;
    logic [IMM_W-1:0]       imm_n;
    logic [NUM_REGS-1:0]    rd_onehot_n;
    logic [DATA_W-1:0]      ext_n;

    assign instr_ready = (state == IDLE) & rst;
    assign busy        = (state != IDLE);
    assign accept      = instr_valid & instr_ready;
    assign dbg_state   = state;

    assign ir_n        = accept ? instr : ir;
    assign cls_n       = ir_n[INSTR_W-1 -: 4];
    assign op_n        = ir_n[INSTR_W-5 -: 4];
    assign rd_n        = ir_n[INSTR_W-9 -: REG_ADDR_W];
    assign imm_n       = ir_n[IMM_W-1:0];
    assign rd_onehot_n = {{(NUM_REGS-1){1'b0}}, 1'b1} << rd_n;

    imm_ext #(
        .IMM_W      (IMM_W),
        .DATA_W     (DATA_W),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_imm_ext (
        .imm (imm_n),
        .ext (ext_n)
    );

    // State, instruction register and EXEC counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ir    <= ir_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; each state lasts one cycle except EXEC.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (cls_n == CLASS_ALU_IMM) ? SRC : ERR;
                end
            end
            SRC: begin
                state_n = IMM;
            end
            IMM: begin
                if (ALU_LAT == 0) begin
                    state_n = LATCH;
                end else begin
                    state_n = EXEC;
                    cnt_n   = LAT_LOAD;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_n = LATCH;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            LATCH: begin
                state_n = WB;
            end
            WB: begin
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            ERR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Moore outputs registered alongside the state, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_op        <= '0;
            rx_out        <= '0;
            alu_in0       <= 1'b0;
            alu_in1       <= 1'b0;
            param2_out    <= '0;
            alu_out_latch <= 1'b0;
            alu_out_en    <= 1'b0;
            rx_in         <= '0;
            pc_inc        <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            alu_op        <= op_window(state_n) ? op_n : 4'h0;
            rx_out        <= (state_n == SRC) ? rd_onehot_n : '0;
            alu_in0       <= (state_n == SRC);
            alu_in1       <= (state_n == IMM);
            param2_out    <= (state_n == IMM) ? ext_n : '0;
            alu_out_latch <= (state_n == LATCH);
            alu_out_en    <= (state_n == WB);
            rx_in         <= (state_n == WB) ? rd_onehot_n : '0;
            pc_inc        <= (state_n == DONE) || (state_n == ERR);
            done          <= (state_n == DONE) || (state_n == ERR);
            err           <= (state_n == ERR);
        end
    end

endmodule

// File: tb/tb_alu_imm_seq.sv
// Bench for alu_imm_seq: two instances (zero-extend/no wait, sign-extend/ALU_LAT=3),
// a driver pushing expected transaction records and a monitor that rebuilds each
// transaction from the bus strobes and compares it when done pulses.
module tb_alu_imm_seq;

    localparam int W = 94;

    logic        clk = 1'b0;
    logic        rst_a   [2];
    logic [15:0] instr_a [2];
    logic        valid_a [2];
    logic        ready_a [2];
    logic        busy_a  [2];
    logic [3:0]  op_a    [2];
    logic [3:0]  rxo_a   [2];
    logic        in0_a   [2];
    logic        in1_a   [2];
    logic [15:0] p2_a    [2];
    logic        lat_a   [2];
    logic        en_a    [2];
    logic [3:0]  rxi_a   [2];
    logic        pc_a    [2];
    logic        done_a  [2];
    logic        err_a   [2];
    logic [2:0]  dbg_a   [2];

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    // clock / reset
    always #5 clk = ~clk;

    alu_imm_seq #(.IMM_SIGNED(1'b0), .ALU_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst_a[0]), .instr(instr_a[0]), .instr_valid(valid_a[0]),
        .instr_ready(ready_a[0]), .busy(busy_a[0]), .alu_op(op_a[0]), .rx_out(rxo_a[0]),
        .alu_in0(in0_a[0]), .alu_in1(in1_a[0]), .param2_out(p2_a[0]),
        .alu_out_latch(lat_a[0]), .alu_out_en(en_a[0]), .rx_in(rxi_a[0]),
        .pc_inc(pc_a[0]), .done(done_a[0]), .err(err_a[0]), .dbg_state(dbg_a[0])
    );

    alu_imm_seq #(.IMM_SIGNED(1'b1), .ALU_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst_a[1]), .instr(instr_a[1]), .instr_valid(valid_a[1]),
        .instr_ready(ready_a[1]), .busy(busy_a[1]), .alu_op(op_a[1]), .rx_out(rxo_a[1]),
        .alu_in0(in0_a[1]), .alu_in1(in1_a[1]), .param2_out(p2_a[1]),
        .alu_out_latch(lat_a[1]), .alu_out_en(en_a[1]), .rx_in(rxi_a[1]),
        .pc_inc(pc_a[1]), .done(done_a[1]), .err(err_a[1]), .dbg_state(dbg_a[1])
    );

    function automatic int lat_of(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    // Transaction record: strobe cycles are counted from the accepting edge (0 = never seen).
    function automatic logic [W-1:0] pack(
        input logic e, input logic [7:0] done_c, input logic [3:0] rxo, input logic [3:0] rxi,
        input logic [3:0] op_src, input logic [3:0] op_lat, input logic [3:0] op_done,
        input logic [15:0] par, input logic [15:0] poth, input logic [7:0] in0_c,
        input logic [7:0] in1_c, input logic [7:0] lat_c, input logic [7:0] wb_c, input logic bad);
        return {e, done_c, rxo, rxi, op_src, op_lat, op_done, par, poth, in0_c, in1_c, lat_c, wb_c, bad};
    endfunction

    // Reference model: expected record for one instruction on instance k.
    function automatic logic [W-1:0] model(input int k, input logic [15:0] ins);
        int          imm;
        int          rd;
        int          lat;
        logic [15:0] par;
        logic [3:0]  rx;
        if (ins[15:12] != 4'h0)
            return pack(1'b1, 8'd1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0,
                        8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        imm = int'(ins[5:0]);
        rd  = int'(ins[7:6]);
        lat = lat_of(k);
        if (k == 1 && imm >= 32) par = 16'(imm - 64);
        else                     par = 16'(imm);
        rx = 4'(1 << rd);
        return pack(1'b0, 8'(5 + lat), rx, rx, ins[11:8], ins[11:8], 4'h0, par, 16'h0,
                    8'd1, 8'd2, 8'(3 + lat), 8'(4 + lat), 1'b0);
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [3:0] cls;
        cls = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        return {cls, 4'($urandom_range(0, 4)), 8'($urandom_range(0, 255))};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, got, exp_v);
        end
    endtask

    task automatic push_exp(input int k, input logic [W-1:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // Wait (from posedge+1) until instance k is ready; bounded.
    task automatic wait_ready(input int k, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 60; i++) begin
            if (ready_a[k]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            waited++;
        end
        if (!ok) chk("ready_timeout", 64'(k), 64'hFFFF);
    endtask

    // Single instruction with valid for one cycle; instr scrambled after acceptance.
    task automatic send(input int k, input logic [15:0] ins);
        bit ok;
        int waited;
        wait_ready(k, ok, waited);
        if (ok) begin
            instr_a[k] = ins;
            valid_a[k] = 1'b1;
            push_exp(k, model(k, ins));
            @(posedge clk); #1;
            valid_a[k] = 1'b0;
            instr_a[k] = rand_instr();
        end
    endtask

    // valid held high; instr changes while busy; checks the accept-to-accept spacing.
    task automatic b2b(input int k, input int n);
        bit          ok;
        int          waited;
        logic [15:0] prev;
        valid_a[k] = 1'b1;
        instr_a[k] = rand_instr();
        prev = 16'h0;
        for (int i = 0; i < n; i++) begin
            wait_ready(k, ok, waited);
            if (!ok) break;
            if (i > 0)
                chk($sformatf("b2b_gap_dut%0d", k), 64'(waited),
                    64'((prev[15:12] == 4'h0) ? 5 + lat_of(k) : 1));
            prev = instr_a[k];
            push_exp(k, model(k, instr_a[k]));
            @(posedge clk); #1;
            instr_a[k] = rand_instr();
        end
        valid_a[k] = 1'b0;
    endtask

    task automatic rand_run(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            send(k, rand_instr());
        end
    endtask

    function automatic logic [36:0] all_outs(input int k);
        return {ready_a[k], busy_a[k], op_a[k], rxo_a[k], in0_a[k], in1_a[k], p2_a[k],
                lat_a[k], en_a[k], rxi_a[k], pc_a[k], done_a[k], err_a[k]};
    endfunction

    // scoreboard monitor
    initial begin : monitor
        bit          act   [2];
        int          cyc   [2];
        logic        o_err [2];
        logic        o_bad [2];
        logic [3:0]  o_rxo [2], o_rxi [2], o_ops [2], o_opl [2];
        logic [15:0] o_par [2], o_poth [2];
        logic [7:0]  o_in0 [2], o_in1 [2], o_lat [2], o_wb [2];
        logic [W-1:0] got;
        logic [W-1:0] exp_v;
        logic [7:0]  c8;
        bit          have;
        for (int k = 0; k < 2; k++) act[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_a[k]) begin
                    act[k] = 1'b0;
                end else if (!act[k]) begin
                    chk($sformatf("idle_quiet_dut%0d", k), 64'(all_outs(k) & 37'h0FFFFFFFFF), 64'h0);
                    if (valid_a[k] && ready_a[k]) begin
                        act[k] = 1'b1;   cyc[k] = 0;
                        o_err[k] = 1'b0; o_bad[k] = 1'b0;
                        o_rxo[k] = '0; o_rxi[k] = '0; o_ops[k] = '0; o_opl[k] = '0;
                        o_par[k] = '0; o_poth[k] = '0;
                        o_in0[k] = '0; o_in1[k] = '0; o_lat[k] = '0; o_wb[k] = '0;
                    end
                end else begin
                    cyc[k]++;
                    c8 = 8'(cyc[k]);
                    if (!busy_a[k] || ready_a[k]) o_bad[k] = 1'b1;
                    if (pc_a[k] !== done_a[k])    o_bad[k] = 1'b1;
                    if (err_a[k]) begin
                        o_err[k] = 1'b1;
                        if (!done_a[k]) o_bad[k] = 1'b1;
                    end
                    if (in0_a[k]) begin
                        if (o_in0[k] != 0) o_bad[k] = 1'b1;
                        o_in0[k] = c8; o_rxo[k] = rxo_a[k]; o_ops[k] = op_a[k];
                    end else if (rxo_a[k] != 0) o_bad[k] = 1'b1;
                    if (in1_a[k]) begin
                        if (o_in1[k] != 0) o_bad[k] = 1'b1;
                        o_in1[k] = c8; o_par[k] = p2_a[k];
                    end else o_poth[k] = o_poth[k] | p2_a[k];
                    if (lat_a[k]) begin
                        if (o_lat[k] != 0) o_bad[k] = 1'b1;
                        o_lat[k] = c8; o_opl[k] = op_a[k];
                    end
                    if (en_a[k]) begin
                        if (o_wb[k] != 0) o_bad[k] = 1'b1;
                        o_wb[k] = c8; o_rxi[k] = rxi_a[k];
                    end else if (rxi_a[k] != 0) o_bad[k] = 1'b1;
                    if (done_a[k]) begin
                        got = pack(o_err[k], c8, o_rxo[k], o_rxi[k], o_ops[k], o_opl[k], op_a[k],
                                   o_par[k], o_poth[k], o_in0[k], o_in1[k], o_lat[k], o_wb[k], o_bad[k]);
                        have = 1'b0;
                        exp_v = '0;
                        if (k == 0 && exp_q0.size() > 0) begin exp_v = exp_q0.pop_front(); have = 1'b1; end
                        if (k == 1 && exp_q1.size() > 0) begin exp_v = exp_q1.pop_front(); have = 1'b1; end
                        n_cmp++;
                        if (!have) begin
                            n_bad++;
                            $display("FAIL unexpected_done dut%0d got %h expected none", k, got);
                        end else if (got !== exp_v) begin
                            n_bad++;
                            $display("FAIL txn dut%0d got %h expected %h", k, got, exp_v);
                        end
                        act[k] = 1'b0;
                    end else if (cyc[k] > 40) begin
                        chk($sformatf("done_timeout_dut%0d", k), 64'(cyc[k]), 64'd0);
                        act[k] = 1'b0;
                    end
                end
            end
        end
    end

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_a[k] = 1'b0; valid_a[k] = 1'b0; instr_a[k] = 16'h0;
        end
        #12;
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset_outs_dut%0d", k), 64'(all_outs(k)), 64'h0);
        @(posedge clk); #1;
        rst_a[0] = 1'b1; rst_a[1] = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("post_reset_ready_dut%0d", k), 64'(ready_a[k]), 64'h1);
            chk($sformatf("post_reset_busy_dut%0d", k), 64'(busy_a[k]), 64'h0);
            chk($sformatf("post_reset_state_dut%0d", k), 64'(dbg_a[k]), 64'h0);
        end

        // directed cases
        send(0, 16'h0044);
        send(0, 16'h017F);
        send(0, 16'h5044);
        send(0, 16'h03C0);
        send(1, 16'h017F);
        send(1, 16'h00C2);
        send(1, 16'h5044);
        send(1, 16'h04E0);

        // back-to-back with instr changing while busy
        b2b(0, 6);
        b2b(1, 6);

        // reset during IMM aborts the sequence
        begin
            bit ok;
            int waited;
            wait_ready(0, ok, waited);
            instr_a[0] = 16'h0044;
            valid_a[0] = 1'b1;
            @(posedge clk); #1;
            valid_a[0] = 1'b0;
            @(posedge clk); #2;
            chk("abort_in_imm", 64'(in1_a[0]), 64'h1);
            rst_a[0] = 1'b0;
            #1;
            chk("abort_outs_zero", 64'(all_outs(0)), 64'h0);
            @(posedge clk); #1;
            rst_a[0] = 1'b1;
            @(posedge clk); #1;
            chk("abort_ready", 64'(ready_a[0]), 64'h1);
            chk("abort_state", 64'(dbg_a[0]), 64'h0);
            repeat (8) begin
                @(posedge clk); #1;
            end
        end

        // randomized traffic on both instances
        fork
            rand_run(0, 30);
            rand_run(1, 30);
        join

        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("q0_drained", 64'(exp_q0.size()), 64'd0);
        chk("q1_drained", 64'(exp_q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
